// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET sequencer: drains the pipeline, writes the cp0
// exception-save fields and redirects the PC to the handler or to EPC.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_VEC  = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Intr_req,
  input  logic        Exc_ov,
  input  logic        Exc_ri,
  input  logic        Exc_sys,
  input  logic        Exc_bp,
  input  logic [31:0] Exc_pc,
  input  logic [31:0] Intr_pc,
  input  logic        Eret,
  input  logic [31:0] Cp0_epc,
  input  logic        Wb_cp0_w_en_in,
  output logic        Cu_cp0_w_en,
  output logic [4:0]  Cu_exec_code,
  output logic [31:0] Epc,
  output logic        Wb_cp0_w_en,
  output logic        Cu_cp0_eret,
  output logic        Flush,
  output logic        Stall,
  output logic        Pc_redirect,
  output logic [31:0] Pc_target,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SAVE,
    S_REDIRECT,
    S_ERET_FLUSH,
    S_ERET_REDIR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic [31:0] r_target;

  logic        w_any_src;
  logic [4:0]  w_src_code;
  logic [31:0] w_src_pc;
  logic        w_latch;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_tgt_load;

  assign w_any_src = Intr_req | Exc_ov | Exc_ri | Exc_sys | Exc_bp;

  // Fixed-priority source select; the interrupt saves the oldest uncommitted PC.
  always_comb begin
    w_src_code = 5'd0;
    w_src_pc   = Exc_pc;
    if (Intr_req) begin
      w_src_code = 5'd0;
      w_src_pc   = Intr_pc;
    end else if (Exc_ov) begin
      w_src_code = 5'd12;
    end else if (Exc_ri) begin
      w_src_code = 5'd10;
    end else if (Exc_sys) begin
      w_src_code = 5'd8;
    end else if (Exc_bp) begin
      w_src_code = 5'd9;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_code   <= '0;
      r_epc    <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_code <= w_src_code;
        r_epc  <= w_src_pc;
      end
      if (w_cnt_load) begin
        r_cnt <= 4'(FLUSH_CYCLES);
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_tgt_load) begin
        r_target <= Cp0_epc;
      end
    end
  end

  // Every output except the WB write gate is a pure decode of r_state and
  // the latched registers; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_tgt_load   = 1'b0;
    Cu_cp0_w_en  = 1'b0;
    Cu_exec_code = '0;
    Epc          = '0;
    Wb_cp0_w_en  = 1'b0;
    Cu_cp0_eret  = 1'b0;
    Flush        = 1'b0;
    Stall        = 1'b0;
    Pc_redirect  = 1'b0;
    Pc_target    = '0;
    Busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        Wb_cp0_w_en = Wb_cp0_w_en_in;
        if (w_any_src) begin
          w_state_nxt = S_FLUSH;
          w_latch     = 1'b1;
          w_cnt_load  = 1'b1;
        end else if (Eret) begin
          w_state_nxt = S_ERET_FLUSH;
        end
      end
      S_FLUSH: begin
        Flush = 1'b1;
        Stall = 1'b1;
        Busy  = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_SAVE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_SAVE: begin
        Cu_cp0_w_en  = 1'b1;
        Cu_exec_code = r_code;
        Epc          = r_epc;
        Stall        = 1'b1;
        Busy         = 1'b1;
        w_state_nxt  = S_REDIRECT;
      end
      S_REDIRECT: begin
        Pc_redirect = 1'b1;
        Pc_target   = HANDLER_VEC;
        Busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERET_FLUSH: begin
        Flush       = 1'b1;
        Stall       = 1'b1;
        Busy        = 1'b1;
        w_tgt_load  = 1'b1;
        w_state_nxt = S_ERET_REDIR;
      end
      S_ERET_REDIR: begin
        Cu_cp0_eret = 1'b1;
        Pc_redirect = 1'b1;
        Pc_target   = r_target;
        Busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: reset, exception/interrupt/ERET
// sequences, priority, busy-drop, WB write gating and mid-sequence reset.
module tb_exc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Intr_req;
  logic        Exc_ov;
  logic        Exc_ri;
  logic        Exc_sys;
  logic        Exc_bp;
  logic [31:0] Exc_pc;
  logic [31:0] Intr_pc;
  logic        Eret;
  logic [31:0] Cp0_epc;
  logic        Wb_cp0_w_en_in;
  logic        Cu_cp0_w_en;
  logic [4:0]  Cu_exec_code;
  logic [31:0] Epc;
  logic        Wb_cp0_w_en;
  logic        Cu_cp0_eret;
  logic        Flush;
  logic        Stall;
  logic        Pc_redirect;
  logic [31:0] Pc_target;
  logic        Busy;

  int unsigned checks;
  int unsigned errors;

  exc_sequencer #(
    .HANDLER_VEC  (32'h0000_0180),
    .FLUSH_CYCLES (3)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Intr_req       (Intr_req),
    .Exc_ov         (Exc_ov),
    .Exc_ri         (Exc_ri),
    .Exc_sys        (Exc_sys),
    .Exc_bp         (Exc_bp),
    .Exc_pc         (Exc_pc),
    .Intr_pc        (Intr_pc),
    .Eret           (Eret),
    .Cp0_epc        (Cp0_epc),
    .Wb_cp0_w_en_in (Wb_cp0_w_en_in),
    .Cu_cp0_w_en    (Cu_cp0_w_en),
    .Cu_exec_code   (Cu_exec_code),
    .Epc            (Epc),
    .Wb_cp0_w_en    (Wb_cp0_w_en),
    .Cu_cp0_eret    (Cu_cp0_eret),
    .Flush          (Flush),
    .Stall          (Stall),
    .Pc_redirect    (Pc_redirect),
    .Pc_target      (Pc_target),
    .Busy           (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Outputs expected in IDLE; only the WB gate may be non-zero.
  task automatic chk_idle(input string tag, input logic wb_exp);
    check({tag, ".busy"},  {31'd0, Busy},         32'd0);
    check({tag, ".flush"}, {31'd0, Flush},        32'd0);
    check({tag, ".stall"}, {31'd0, Stall},        32'd0);
    check({tag, ".redir"}, {31'd0, Pc_redirect},  32'd0);
    check({tag, ".tgt"},   Pc_target,             32'd0);
    check({tag, ".cuw"},   {31'd0, Cu_cp0_w_en},  32'd0);
    check({tag, ".code"},  {27'd0, Cu_exec_code}, 32'd0);
    check({tag, ".epc"},   Epc,                   32'd0);
    check({tag, ".eret"},  {31'd0, Cu_cp0_eret},  32'd0);
    check({tag, ".wb"},    {31'd0, Wb_cp0_w_en},  {31'd0, wb_exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    Intr_req = 1'b0; Exc_ov = 1'b0; Exc_ri = 1'b0; Exc_sys = 1'b0; Exc_bp = 1'b0;
    Exc_pc = '0; Intr_pc = '0; Eret = 1'b0; Cp0_epc = '0; Wb_cp0_w_en_in = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    chk_idle("reset", 1'b0);

    // Exc_sys at edge k: flush k+1..k+3, save at k+4, redirect at k+5
    Exc_sys = 1'b1; Exc_pc = 32'h400;
    tick();
    Exc_sys = 1'b0; Exc_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("sys.flush", {31'd0, Flush}, 32'd1);
      check("sys.stall", {31'd0, Stall}, 32'd1);
      check("sys.busy",  {31'd0, Busy},  32'd1);
      check("sys.cuw0",  {31'd0, Cu_cp0_w_en}, 32'd0);
      tick();
    end
    check("sys.save.flush", {31'd0, Flush},        32'd0);
    check("sys.save.stall", {31'd0, Stall},        32'd1);
    check("sys.save.cuw",   {31'd0, Cu_cp0_w_en},  32'd1);
    check("sys.save.code",  {27'd0, Cu_exec_code}, 32'd8);
    check("sys.save.epc",   Epc,                   32'h400);
    check("sys.save.redir", {31'd0, Pc_redirect},  32'd0);
    tick();
    check("sys.redir",     {31'd0, Pc_redirect}, 32'd1);
    check("sys.redir.tgt", Pc_target,            32'h180);
    check("sys.redir.busy",{31'd0, Busy},        32'd1);
    check("sys.redir.epc", Epc,                  32'd0);
    check("sys.redir.cuw", {31'd0, Cu_cp0_w_en}, 32'd0);
    tick();
    chk_idle("sys.end", 1'b0);

    // Interrupt beats overflow and ERET; EPC comes from Intr_pc
    Intr_req = 1'b1; Exc_ov = 1'b1; Eret = 1'b1;
    Intr_pc = 32'h800; Exc_pc = 32'h444; Cp0_epc = 32'h999;
    tick();
    Intr_req = 1'b0; Exc_ov = 1'b0; Eret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("prio.flush", {31'd0, Flush},       32'd1);
      check("prio.eret",  {31'd0, Cu_cp0_eret}, 32'd0);
      tick();
    end
    check("prio.cuw",  {31'd0, Cu_cp0_w_en},  32'd1);
    check("prio.code", {27'd0, Cu_exec_code}, 32'd0);
    check("prio.epc",  Epc,                   32'h800);
    check("prio.eret", {31'd0, Cu_cp0_eret},  32'd0);
    tick();
    check("prio.redir", {31'd0, Pc_redirect}, 32'd1);
    check("prio.tgt",   Pc_target,            32'h180);
    check("prio.eret",  {31'd0, Cu_cp0_eret}, 32'd0);
    tick();
    chk_idle("prio.end", 1'b0);

    // ERET: one flush cycle, then redirect to sampled EPC
    Eret = 1'b1; Cp0_epc = 32'h1234;
    tick();
    Eret = 1'b0;
    check("eret.flush", {31'd0, Flush},       32'd1);
    check("eret.stall", {31'd0, Stall},       32'd1);
    check("eret.busy",  {31'd0, Busy},        32'd1);
    check("eret.r0",    {31'd0, Pc_redirect}, 32'd0);
    check("eret.e0",    {31'd0, Cu_cp0_eret}, 32'd0);
    tick();
    Cp0_epc = 32'h5678;
    check("eret.eret",  {31'd0, Cu_cp0_eret}, 32'd1);
    check("eret.redir", {31'd0, Pc_redirect}, 32'd1);
    check("eret.tgt",   Pc_target,            32'h1234);
    check("eret.fl0",   {31'd0, Flush},       32'd0);
    check("eret.cuw",   {31'd0, Cu_cp0_w_en}, 32'd0);
    tick();
    chk_idle("eret.end", 1'b0);

    // WB cp0 write passes only in IDLE, held through an Exc_ri sequence
    Wb_cp0_w_en_in = 1'b1;
    #1;
    check("wb.idle", {31'd0, Wb_cp0_w_en}, 32'd1);
    Exc_ri = 1'b1; Exc_pc = 32'h500;
    tick();
    Exc_ri = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wb.flush", {31'd0, Wb_cp0_w_en}, 32'd0);
      tick();
    end
    check("wb.save.cuw",  {31'd0, Cu_cp0_w_en},  32'd1);
    check("wb.save.wb",   {31'd0, Wb_cp0_w_en},  32'd0);
    check("wb.save.code", {27'd0, Cu_exec_code}, 32'd10);
    tick();
    check("wb.redir", {31'd0, Wb_cp0_w_en}, 32'd0);
    tick();
    chk_idle("wb.end", 1'b1);
    Wb_cp0_w_en_in = 1'b0;

    // Exc_bp arriving during an Exc_ri flush is dropped
    Exc_ri = 1'b1; Exc_pc = 32'h600;
    tick();
    Exc_ri = 1'b0;
    Exc_bp = 1'b1; Exc_pc = 32'h700;
    tick();
    check("drop.flush2", {31'd0, Flush}, 32'd1);
    tick();
    Exc_bp = 1'b0; Exc_pc = 32'h0;
    check("drop.flush3", {31'd0, Flush}, 32'd1);
    tick();
    check("drop.cuw",  {31'd0, Cu_cp0_w_en},  32'd1);
    check("drop.code", {27'd0, Cu_exec_code}, 32'd10);
    check("drop.epc",  Epc,                   32'h600);
    tick();
    check("drop.redir", {31'd0, Pc_redirect}, 32'd1);
    tick();
    chk_idle("drop.idle", 1'b0);
    tick();
    chk_idle("drop.noqueue", 1'b0);

    // Reset in the second flush cycle aborts the sequence
    Exc_ov = 1'b1; Exc_pc = 32'h900;
    tick();
    Exc_ov = 1'b0;
    tick();
    check("rst.flush2", {31'd0, Flush}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_idle("rst.next", 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst.cuw",   {31'd0, Cu_cp0_w_en}, 32'd0);
      check("rst.redir", {31'd0, Pc_redirect}, 32'd0);
      check("rst.busy",  {31'd0, Busy},        32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
